// File: rtl/mem_port_scheduler_if.sv
// Bundle of requester, response and RAM-side signals for mem_port_scheduler.
// The scheduler uses the slave modport; the requester/RAM side uses master.
interface mem_port_scheduler_if #(
    parameter int DEPTH     = 8,
    parameter int DATA_SIZE = 32,
    parameter int NUM_WR    = 2
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SW = DATA_SIZE / 8;

    logic [NUM_WR-1:0]           wr_req;
    logic [NUM_WR*AW-1:0]        wr_addr;
    logic [NUM_WR*DATA_SIZE-1:0] wr_data;
    logic [NUM_WR*SW-1:0]        wr_strb;
    logic [NUM_WR-1:0]           wr_gnt;
    logic                        rd_valid;
    logic [AW-1:0]               rd_addr;
    logic                        rd_ready;
    logic                        rsp_valid;
    logic [DATA_SIZE-1:0]        rsp_data;
    logic                        rsp_ready;
    logic [AW-1:0]               mem_addra;
    logic [DATA_SIZE-1:0]        mem_dina;
    logic [SW-1:0]               mem_wea;
    logic [AW-1:0]               mem_addrb;
    logic [DATA_SIZE-1:0]        mem_doutb;

    modport master (
        output wr_req, wr_addr, wr_data, wr_strb, rd_valid, rd_addr, rsp_ready, mem_doutb,
        input  wr_gnt, rd_ready, rsp_valid, rsp_data, mem_addra, mem_dina, mem_wea, mem_addrb
    );

    modport slave (
        input  wr_req, wr_addr, wr_data, wr_strb, rd_valid, rd_addr, rsp_ready, mem_doutb,
        output wr_gnt, rd_ready, rsp_valid, rsp_data, mem_addra, mem_dina, mem_wea, mem_addrb
    );
endinterface

// File: rtl/mem_port_scheduler.sv
// Round-robin write arbiter for RAM port A plus a 2-deep buffered read sequencer for port B.
// Optional same-cycle write-to-read forwarding is enabled with MEM_SCHED_RAW_FWD_EN.
module mem_port_scheduler #(
    parameter int DEPTH     = 8,
    parameter int DATA_SIZE = 32,
    parameter int NUM_WR    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_port_scheduler_if.slave  bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SW = DATA_SIZE / 8;
    localparam int PW = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;

    logic [AW-1:0]        req_addr [NUM_WR];
    logic [DATA_SIZE-1:0] req_data [NUM_WR];
    logic [SW-1:0]        req_strb [NUM_WR];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WR; gi++) begin : g_unpack
            assign req_addr[gi] = bus.wr_addr[gi*AW +: AW];
            assign req_data[gi] = bus.wr_data[gi*DATA_SIZE +: DATA_SIZE];
            assign req_strb[gi] = bus.wr_strb[gi*SW +: SW];
        end
    endgenerate

    // ---------------- write arbiter ----------------
    logic [PW-1:0] ptr_reg, ptr_next;
    logic [PW-1:0] win_idx;
    logic          win_valid;
    int            idx;

    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int k = 0; k < NUM_WR; k++) begin
            idx = int'(ptr_reg) + k;
            if (idx >= NUM_WR) idx = idx - NUM_WR;
            if (rst_n && !win_valid && bus.wr_req[idx]) begin
                win_valid = 1'b1;
                win_idx   = PW'(idx);
            end
        end
    end

    always_comb begin
        ptr_next = ptr_reg;
        if (win_valid) ptr_next = (int'(win_idx) == NUM_WR - 1) ? '0 : win_idx + PW'(1);
    end

    assign bus.wr_gnt    = win_valid ? (NUM_WR'(1) << win_idx) : '0;
    assign bus.mem_addra = req_addr[win_idx];
    assign bus.mem_dina  = req_data[win_idx];
    assign bus.mem_wea   = win_valid ? req_strb[win_idx] : '0;

    // ---------------- read sequencer ----------------
    logic [1:0]           occ_reg;
    logic                 inflight_reg;
    logic                 rd_ptr_reg, wr_ptr_reg;
    logic [AW-1:0]        addrb_reg;
    logic [DATA_SIZE-1:0] buf_mem [2];
    logic [DATA_SIZE-1:0] capture_data;
    logic [2:0]           pending;
    logic                 pop, accept;

    assign pop           = bus.rsp_valid & bus.rsp_ready;
    // Slots already committed (buffered + one RAM read in flight) after this cycle's pop
    assign pending       = {1'b0, occ_reg} + {2'b00, inflight_reg} - {2'b00, pop};
    assign bus.rd_ready  = rst_n & (pending < 3'd2);
    assign accept        = bus.rd_valid & bus.rd_ready;
    assign bus.mem_addrb = accept ? bus.rd_addr : addrb_reg;
    assign bus.rsp_valid = (occ_reg != 2'd0);
    assign bus.rsp_data  = buf_mem[rd_ptr_reg];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg      <= '0;
            occ_reg      <= 2'd0;
            inflight_reg <= 1'b0;
            rd_ptr_reg   <= 1'b0;
            wr_ptr_reg   <= 1'b0;
            addrb_reg    <= '0;
        end else begin
            ptr_reg      <= ptr_next;
            inflight_reg <= accept;
            if (accept) addrb_reg <= bus.rd_addr;
            if (inflight_reg) wr_ptr_reg <= ~wr_ptr_reg;
            if (pop) rd_ptr_reg <= ~rd_ptr_reg;
            occ_reg      <= occ_reg + {1'b0, inflight_reg} - {1'b0, pop};
        end
    end

    // RAM data is valid the cycle after the accepted address
    always_ff @(posedge clk) begin
        if (inflight_reg) buf_mem[wr_ptr_reg] <= capture_data;
    end

`ifdef MEM_SCHED_RAW_FWD_EN
    logic                 fwd_hit;
    logic                 fwd_valid_reg;
    logic [DATA_SIZE-1:0] fwd_data_reg;
    logic [SW-1:0]        fwd_strb_reg;

    assign fwd_hit = accept & win_valid & (bus.mem_addra == bus.rd_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_valid_reg <= 1'b0;
            fwd_data_reg  <= '0;
            fwd_strb_reg  <= '0;
        end else begin
            fwd_valid_reg <= fwd_hit;
            if (fwd_hit) begin
                fwd_data_reg <= bus.mem_dina;
                fwd_strb_reg <= bus.mem_wea;
            end
        end
    end

    generate
        for (gi = 0; gi < SW; gi++) begin : g_fwd
            assign capture_data[gi*8 +: 8] = (fwd_valid_reg & fwd_strb_reg[gi]) ?
                                             fwd_data_reg[gi*8 +: 8] : bus.mem_doutb[gi*8 +: 8];
        end
    endgenerate
`else
    assign capture_data = bus.mem_doutb;
`endif

endmodule

// File: tb/tb_mem_port_scheduler.sv
// Self-checking bench for mem_port_scheduler: vector table, directed corner sequences,
// and randomized traffic against a queue/array reference model with a behavioural RAM.
module tb_mem_port_scheduler;
    localparam int DEPTH = 8;
    localparam int DW    = 32;
    localparam int NW    = 2;
    localparam int AW    = 3;
    localparam int SW    = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_scheduler_if #(.DEPTH(DEPTH), .DATA_SIZE(DW), .NUM_WR(NW)) bus ();

    mem_port_scheduler #(.DEPTH(DEPTH), .DATA_SIZE(DW), .NUM_WR(NW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h cycle=%0d", nm, act, exp, cyc);
        end
    endtask

    // Behavioural RAM: byte writes on port A, 1-cycle registered read on port B
    logic [DW-1:0] ram [DEPTH] = '{default: '0};
    always @(posedge clk) begin
        bus.mem_doutb <= ram[bus.mem_addrb];
        for (int b = 0; b < SW; b++)
            if (bus.mem_wea[b]) ram[bus.mem_addra][b*8 +: 8] <= bus.mem_dina[b*8 +: 8];
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        rq[$];
    logic [31:0] shadow [DEPTH] = '{default: '0};
    int          rr_ptr   = 0;
    int          m_gidx   = -1;
    logic        m_accept = 1'b0;
    logic        m_pop    = 1'b0;

    always @(negedge clk) begin
        logic exp_valid;
        logic exp_rdy;
        #2;
        if (!rst_n) begin
            chk("rst_gnt", {30'd0, bus.wr_gnt}, 32'd0);
            chk("rst_wea", {28'd0, bus.mem_wea}, 32'd0);
            chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
            chk("rst_rd_ready", {31'd0, bus.rd_ready}, 32'd0);
            m_gidx   = -1;
            m_accept = 1'b0;
            m_pop    = 1'b0;
        end else begin
            m_gidx = -1;
            for (int k = 0; k < NW; k++)
                if (m_gidx < 0 && bus.wr_req[(rr_ptr + k) % NW]) m_gidx = (rr_ptr + k) % NW;
            chk("gnt", {30'd0, bus.wr_gnt}, (m_gidx < 0) ? 32'd0 : (32'd1 << m_gidx));
            if (m_gidx < 0) begin
                chk("wea_idle", {28'd0, bus.mem_wea}, 32'd0);
            end else begin
                chk("wea", {28'd0, bus.mem_wea}, {28'd0, bus.wr_strb[m_gidx*SW +: SW]});
                chk("addra", {29'd0, bus.mem_addra}, {29'd0, bus.wr_addr[m_gidx*AW +: AW]});
                chk("dina", bus.mem_dina, bus.wr_data[m_gidx*DW +: DW]);
            end
            exp_valid = (rq.size() > 0) && (rq[0].cyc <= cyc - 2);
            chk("rsp_valid", {31'd0, bus.rsp_valid}, {31'd0, exp_valid});
            if (exp_valid) chk("rsp_data", bus.rsp_data, rq[0].data);
            m_pop    = exp_valid & bus.rsp_ready;
            exp_rdy  = (rq.size() - int'(m_pop)) < 2;
            chk("rd_ready", {31'd0, bus.rd_ready}, {31'd0, exp_rdy});
            m_accept = bus.rd_valid & exp_rdy;
        end
    end

    always @(posedge clk) begin
        logic [31:0] d;
        if (!rst_n) begin
            rq.delete();
            rr_ptr = 0;
        end else begin
            if (m_pop) void'(rq.pop_front());
            if (m_accept) begin
                d = shadow[bus.rd_addr];
`ifdef MEM_SCHED_RAW_FWD_EN
                if (m_gidx >= 0 && bus.wr_addr[m_gidx*AW +: AW] == bus.rd_addr)
                    for (int b = 0; b < SW; b++)
                        if (bus.wr_strb[m_gidx*SW + b]) d[b*8 +: 8] = bus.wr_data[m_gidx*DW + b*8 +: 8];
`endif
                rq.push_back('{d, cyc});
            end
            if (m_gidx >= 0) begin
                for (int b = 0; b < SW; b++)
                    if (bus.wr_strb[m_gidx*SW + b])
                        shadow[bus.wr_addr[m_gidx*AW +: AW]][b*8 +: 8] = bus.wr_data[m_gidx*DW + b*8 +: 8];
                rr_ptr = (m_gidx + 1) % NW;
            end
        end
        cyc++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        bus.wr_req    = '0;
        bus.rd_valid  = 1'b0;
        bus.rsp_ready = 1'b1;
    endtask

    task automatic do_write(input int r, input logic [AW-1:0] a, input logic [31:0] d, input logic [SW-1:0] s);
        bus.wr_addr[r*AW +: AW] = a;
        bus.wr_data[r*DW +: DW] = d;
        bus.wr_strb[r*SW +: SW] = s;
        bus.wr_req              = NW'(1) << r;
        #1;
        chk("wr_gnt_single", {30'd0, bus.wr_gnt}, 32'd1 << r);
        @(negedge clk);
        bus.wr_req = '0;
    endtask

    // Called at the negedge of the accept cycle; returns response data and latency
    task automatic wait_rsp(input string nm, output logic [31:0] d, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            bus.rd_valid = 1'b0;
            bus.wr_req   = '0;
            #1;
            lat++;
        end while (!bus.rsp_valid && lat < 10);
        if (!bus.rsp_valid) chk({nm, "_timeout"}, 32'd0, 32'd1);
        d = bus.rsp_data;
    endtask

    task automatic rand_cycle();
        bus.wr_req    = NW'($urandom);
        bus.wr_addr   = (NW*AW)'($urandom);
        bus.wr_data   = {$urandom, $urandom};
        bus.wr_strb   = (NW*SW)'($urandom);
        bus.rd_valid  = 1'($urandom);
        bus.rd_addr   = AW'($urandom);
        bus.rsp_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
    endtask

    typedef struct {
        logic [1:0] req;
        logic [1:0] gnt;
        logic [3:0] wea;
        logic [2:0] addra;
    } rr_vec_t;

    rr_vec_t     rr_tab [11];
    logic [31:0] d;
    int          lat;
    int          n_acc;
    int          n_rsp;
    int          nxt;
    int          stream_cycles;
    logic [31:0] exp_full, exp_byte;

    initial begin
        rr_tab[0]  = '{2'b11, 2'b01, 4'h3, 3'd5};
        rr_tab[1]  = '{2'b11, 2'b10, 4'hC, 3'd6};
        rr_tab[2]  = '{2'b11, 2'b01, 4'h3, 3'd5};
        rr_tab[3]  = '{2'b11, 2'b10, 4'hC, 3'd6};
        rr_tab[4]  = '{2'b10, 2'b10, 4'hC, 3'd6};
        rr_tab[5]  = '{2'b00, 2'b00, 4'h0, 3'd0};
        rr_tab[6]  = '{2'b10, 2'b10, 4'hC, 3'd6};
        rr_tab[7]  = '{2'b01, 2'b01, 4'h3, 3'd5};
        rr_tab[8]  = '{2'b01, 2'b01, 4'h3, 3'd5};
        rr_tab[9]  = '{2'b11, 2'b10, 4'hC, 3'd6};
        rr_tab[10] = '{2'b11, 2'b01, 4'h3, 3'd5};

        bus.wr_req    = '0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.wr_strb   = '0;
        bus.rd_valid  = 1'b0;
        bus.rd_addr   = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Round-robin vectors
        bus.wr_addr = {3'd6, 3'd5};
        bus.wr_data = {32'hB1B1B1B1, 32'hA0A0A0A0};
        bus.wr_strb = {4'hC, 4'h3};
        for (int i = 0; i < 11; i++) begin
            bus.wr_req = rr_tab[i].req;
            #1;
            chk($sformatf("rr_gnt[%0d]", i), {30'd0, bus.wr_gnt}, {30'd0, rr_tab[i].gnt});
            chk($sformatf("rr_wea[%0d]", i), {28'd0, bus.mem_wea}, {28'd0, rr_tab[i].wea});
            if (rr_tab[i].gnt != 2'b00)
                chk($sformatf("rr_addra[%0d]", i), {29'd0, bus.mem_addra}, {29'd0, rr_tab[i].addra});
            @(negedge clk);
        end
        idle();

        // Write then read next cycle
        do_write(0, 3'd0, 32'h000000FE, 4'b0001);
        bus.rd_valid = 1'b1;
        bus.rd_addr  = 3'd0;
        #1;
        chk("wr_rd_ready", {31'd0, bus.rd_ready}, 32'd1);
        wait_rsp("wr_rd", d, lat);
        chk("wr_rd_data", d, 32'h000000FE);
        chk("wr_rd_latency", lat, 2);
        @(negedge clk);

        // Back-pressure then streaming
        for (int a = 1; a < 8; a++) do_write(1, AW'(a), 32'h10000000 + a, 4'hF);
        bus.rsp_ready = 1'b0;
        n_acc = 0;
        for (int t = 0; t < 6; t++) begin
            bus.rd_valid = 1'b1;
            bus.rd_addr  = AW'(n_acc);
            #1;
            if (bus.rd_ready) n_acc++;
            @(negedge clk);
        end
        chk("bp_accepts", n_acc, 2);
        chk("bp_rd_ready_low", {31'd0, bus.rd_ready}, 32'd0);
        bus.rsp_ready = 1'b1;
        nxt = n_acc;
        n_rsp = 0;
        stream_cycles = -1;
        for (int t = 0; t < 40 && n_rsp < 8; t++) begin
            bus.rd_valid = (nxt < 8);
            bus.rd_addr  = AW'(nxt);
            #1;
            if (bus.rsp_valid) n_rsp++;
            if (bus.rd_valid && bus.rd_ready) begin
                nxt++;
                if (nxt == 8) stream_cycles = t + 1;
            end
            @(negedge clk);
        end
        chk("bp_responses", n_rsp, 8);
        chk("bp_stream_cycles", stream_cycles, 6);
        idle();
        @(negedge clk);

        // Same-cycle write/read collision, full then partial strobe
`ifdef MEM_SCHED_RAW_FWD_EN
        exp_full = 32'hAABBCCDD;
        exp_byte = 32'h1122CC44;
`else
        exp_full = 32'h11223344;
        exp_byte = 32'h11223344;
`endif
        for (int c = 0; c < 2; c++) begin
            do_write(0, 3'd3, 32'h11223344, 4'hF);
            bus.wr_addr[2:0]  = 3'd3;
            bus.wr_data[31:0] = 32'hAABBCCDD;
            bus.wr_strb[3:0]  = (c == 0) ? 4'b1111 : 4'b0010;
            bus.wr_req        = 2'b01;
            bus.rd_valid      = 1'b1;
            bus.rd_addr       = 3'd3;
            #1;
            chk("col_rd_ready", {31'd0, bus.rd_ready}, 32'd1);
            wait_rsp("col", d, lat);
            chk((c == 0) ? "col_full" : "col_byte", d, (c == 0) ? exp_full : exp_byte);
            @(negedge clk);
        end

        // Reset in the middle of random traffic
        for (int t = 0; t < 20; t++) rand_cycle();
        bus.wr_req   = 2'b11;
        bus.rd_valid = 1'b1;
        rst_n = 1'b0;
        for (int t = 0; t < 3; t++) begin
            #1;
            chk("mid_rst_gnt", {30'd0, bus.wr_gnt}, 32'd0);
            chk("mid_rst_rd_ready", {31'd0, bus.rd_ready}, 32'd0);
            @(negedge clk);
        end
        idle();
        rst_n = 1'b1;
        #1;
        chk("post_rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        @(negedge clk);
        do_write(1, 3'd5, 32'h5555AAAA, 4'hF);
        bus.rd_valid = 1'b1;
        bus.rd_addr  = 3'd5;
        #1;
        chk("post_rst_rd_ready", {31'd0, bus.rd_ready}, 32'd1);
        wait_rsp("post_rst", d, lat);
        chk("post_rst_data", d, 32'h5555AAAA);
        chk("post_rst_latency", lat, 2);
        @(negedge clk);

        // Randomized traffic checked by the reference model
        for (int t = 0; t < 400; t++) rand_cycle();
        idle();
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_port_scheduler.md
Name: mem_port_scheduler

Overview:
- Controller that sits between DMA-side requesters and one simple dual-port RAM: port A write-only, port B read-only, port B read latency 1 cycle, byte-wide write enables.
- Shares port A among NUM_WR write requesters with a round-robin arbiter.
- Sequences port B reads through a valid/ready request channel and a 2-entry response buffer, so the free-running RAM output is captured on exactly the right cycle and downstream back-pressure is absorbed.

Parameters:
- DEPTH, 8, RAM word count; address width AW = $clog2(DEPTH).
- DATA_SIZE, 32, word width in bits; strobe width SW = DATA_SIZE/8.
- NUM_WR, 2, number of write requesters (>=1).

Ports:
- clk  in  1  single clock for the block and the RAM.
- rst_n  in  1  reset, asynchronous assert, active-low.
- wr_req  in  NUM_WR  per-requester write request.
- wr_addr  in  NUM_WR*AW  packed addresses; requester i at [i*AW +: AW].
- wr_data  in  NUM_WR*DATA_SIZE  packed write data.
- wr_strb  in  NUM_WR*SW  packed byte strobes.
- wr_gnt  out  NUM_WR  one-hot grant; a write completes in any cycle where wr_req[i] & wr_gnt[i].
- rd_valid  in  1  read request valid.
- rd_addr  in  AW  read address.
- rd_ready  out  1  read request accepted when rd_valid & rd_ready.
- rsp_valid  out  1  read data valid.
- rsp_data  out  DATA_SIZE  read data.
- rsp_ready  in  1  downstream accepts read data.
- mem_addra  out  AW  RAM port A address.
- mem_dina  out  DATA_SIZE  RAM port A data.
- mem_wea  out  SW  RAM port A byte write enable.
- mem_addrb  out  AW  RAM port B address.
- mem_doutb  in  DATA_SIZE  RAM port B data; valid 1 cycle after address.

Behaviour:
- Reset (async, rst_n=0):
  - wr_gnt=0, mem_wea=0, rsp_valid=0.
  - Round-robin pointer=0, buffer empty, in-flight flag cleared.
  - mem_addrb register=0; rd_ready=0 while rst_n=0.
  - Reset mid-operation drops in-flight reads and buffered data; no response is produced for them.
- Write arbiter (combinational grant, registered pointer):
  - Winner = first i with wr_req[i]=1, searching from ptr upward with wrap.
  - wr_gnt is one-hot to the winner, or 0 if no request.
  - mem_addra, mem_dina, mem_wea are driven combinationally from the winner's slice; mem_wea=0 when there is no winner.
  - All-zero strobe: still granted, consumed and rotated; the RAM is not modified.
  - On a grant, ptr <= winner+1 (mod NUM_WR). With no grant, ptr holds.
  - Grant does not depend on the read path; one write per cycle maximum.
- Read sequencing:
  - occ = buffer occupancy (0..2); inflight = 1 if a read was accepted last cycle.
  - pop = rsp_valid & rsp_ready.
  - rd_ready = rst_n & ((occ + inflight - pop) < 2).
  - Accept in cycle N: mem_addrb is driven combinationally with rd_addr in cycle N, and the internal address register is updated. When no read is accepted, mem_addrb holds the last accepted address.
  - Cycle N+1: mem_doutb is captured into the buffer tail at the end of the cycle.
  - Cycle N+2: earliest rsp_valid. Request-to-response latency is 2 cycles.
  - Buffer is FIFO ordered, 2 entries. Simultaneous push and pop in the same cycle is legal and occupancy stays constant.
  - With rsp_ready held high, sustained throughput is 1 read per cycle.
  - Back-pressure: rsp_valid and rsp_data are held stable while rsp_ready=0. No request is accepted that would overflow the buffer.
- Read/write same address in the same cycle: the RAM returns old data; no forwarding unless the optional feature is enabled.
- Reads and writes proceed independently in the same cycle.

Optional Feature:
- Macro MEM_SCHED_RAW_FWD_EN.
- Defined:
  - When a read is accepted in the same cycle as a granted write to the same address, register the write data and strobe.
  - At capture (N+1), each byte whose strobe was set takes the written data; other bytes take mem_doutb.
  - The response therefore reflects the new data. Adds one DATA_SIZE+SW+1 bit register.
- Undefined:
  - Response returns old RAM content for a same-cycle same-address collision.
  - No extra logic is present.

Test Plan:
- Reset then idle: rst_n low for 3 cycles mid-burst -> wr_gnt=0, mem_wea=0, rsp_valid=0, rd_ready=0 during reset; the first read after release returns data at N+2 and no stale response appears.
- Round-robin: NUM_WR=2, both wr_req held high for 4 cycles -> grants 0,1,0,1. Then only requester 1 requests -> immediate grant with no idle cycle.
- Write then read: write 0x000000FE strobe 4'b0001 to addr 0, then read addr 0 on the next cycle -> rsp_data[7:0]=0xFE at accept+2.
- Back-pressure: issue reads to addrs 0,1,2,3 back to back with rsp_ready=0 -> rd_ready drops after 2 accepts. Then raise rsp_ready -> responses arrive in order with no loss or duplicates, and 1/cycle streaming resumes.
- Collision: same-cycle write 0xAABBCCDD strobe 4'b1111 and read of the same address holding 0x11223344 -> response 0x11223344 without MEM_SCHED_RAW_FWD_EN, 0xAABBCCDD with it. Strobe 4'b0010 with the macro defined -> 0x1122CC44.
